// File: rtl/lsu_pkg.sv
// Shared types and constants for the doubleword load/store unit (dmem_lsu).
package lsu_pkg;

    localparam int DEPTH_DEFAULT = 256;
    localparam int IDX_W         = 8;
    localparam int CNT_W         = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Doubleword index from a byte address; upper bits alias modulo 2048 bytes.
    function automatic logic [IDX_W-1:0] word_index(input logic [63:0] addr);
        return addr[IDX_W+2:3];
    endfunction

endpackage

// File: rtl/lsu_mem_array.sv
// DEPTH x 64-bit storage for dmem_lsu: synchronous write, registered synchronous read.
module lsu_mem_array
    import lsu_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [63:0]      wdata,
    output logic [63:0]      rdata
);

    logic [63:0] memory [DEPTH];

    // NOTE: the storage array has no reset so it maps onto RAM and keeps its contents across rst.
    always_ff @(posedge clk) begin
        if (en && we) begin
            memory[idx] <= wdata;
        end
    end

    // Stores return zero data, so the read register is cleared on a write access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= we ? 64'd0 : memory[idx];
        end
    end

endmodule

// File: rtl/dmem_lsu.sv
// Single-outstanding doubleword load/store unit with fixed LATENCY response timing.
// Optional build macro: MISALIGN_TRAP_EN (trap accesses whose addr[2:0] != 0).
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEFAULT,
    parameter int LATENCY = 2
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic             lat_we;
    logic             lat_mis;
    logic [IDX_W-1:0] lat_idx;
    logic [63:0]      lat_wdata;
    logic             err_q;
    logic [63:0]      mem_rdata;
    logic             mis_now;
    logic             accept, access, consume;
    logic             addr_unused;

`ifdef MISALIGN_TRAP_EN
    assign mis_now     = |req_addr[2:0];
    assign addr_unused = ^req_addr[63:IDX_W+3];
`else
    assign mis_now     = 1'b0;
    assign addr_unused = ^{req_addr[63:IDX_W+3], req_addr[2:0]};
`endif

    assign req_ready = (state == ST_IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign access    = (state == ST_WAIT) && (cnt == '0);
    assign consume   = (state == ST_RESP) && resp_ready;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept)  state_next = ST_WAIT;
            ST_WAIT: if (access)  state_next = ST_RESP;
            ST_RESP: if (consume) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            lat_we     <= 1'b0;
            lat_mis    <= 1'b0;
            lat_idx    <= '0;
            lat_wdata  <= '0;
            resp_valid <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                cnt       <= CNT_W'(LATENCY - 1);
                lat_we    <= req_we;
                lat_mis   <= mis_now;
                lat_idx   <= word_index(req_addr);
                lat_wdata <= req_wdata;
            end else if ((state == ST_WAIT) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end

            if (access) begin
                resp_valid <= 1'b1;
                err_q      <= lat_mis;
            end else if (consume) begin
                resp_valid <= 1'b0;
                err_q      <= 1'b0;
            end
        end
    end

    // A trapped access never reaches the array, so its stale read data is masked.
    assign resp_err   = err_q;
    assign resp_rdata = err_q ? 64'd0 : mem_rdata;

    lsu_mem_array #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .rst   (rst),
        .en    (access && !lat_mis),
        .we    (lat_we),
        .idx   (lat_idx),
        .wdata (lat_wdata),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: directed corner cases plus randomized traffic vs. a byte-address model.
module tb_dmem_lsu;

    localparam int LATENCY = 2;
    localparam int DEPTH   = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [63:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err, busy;
    logic [63:0] resp_rdata;

    dmem_lsu #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          due;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] ref_mem [256];
    int          checks = 0;
    int          errors = 0;

    function automatic int ref_idx(input logic [63:0] a);
        return int'((a % 64'd2048) / 64'd8);
    endfunction

    function automatic bit ref_mis(input logic [63:0] a);
`ifdef MISALIGN_TRAP_EN
        return (a % 64'd8) != 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares each presented response against the head of the scoreboard.
    bit          presenting = 1'b0;
    logic [63:0] held_rdata;
    logic        held_err;

    always @(negedge clk) begin
        if (rst) begin
            presenting = 1'b0;
        end else if (resp_valid) begin
            check("req_ready_low_in_resp", {63'd0, req_ready}, 64'd0);
            if (!presenting) begin
                presenting = 1'b1;
                held_rdata = resp_rdata;
                held_err   = resp_err;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got rdata %h with empty scoreboard", resp_rdata);
                end else begin
                    check({sb[0].tag, "_timing"}, 64'(cyc), 64'(sb[0].due));
                    check({sb[0].tag, "_rdata"}, resp_rdata, sb[0].rdata);
                    check({sb[0].tag, "_err"}, {63'd0, resp_err}, {63'd0, sb[0].err});
                end
            end else begin
                check("resp_rdata_hold", resp_rdata, held_rdata);
                check("resp_err_hold", {63'd0, resp_err}, {63'd0, held_err});
            end
            if (resp_ready) begin
                if (sb.size() != 0) void'(sb.pop_front());
                presenting = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 50) begin
            step();
            n++;
        end
    endtask

    task automatic issue(input string tag, input logic we, input logic [63:0] addr,
                         input logic [63:0] wdata, input int delay);
        exp_t e;
        int   n;
        wait_ready();
        if (!req_ready) begin
            check({tag, "_req_ready_timeout"}, {63'd0, req_ready}, 64'd1);
            return;
        end
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        e.tag = tag;
        e.due = cyc + 1 + LATENCY;
        if (ref_mis(addr)) begin
            e.rdata = 64'd0;
            e.err   = 1'b1;
        end else if (we) begin
            e.rdata = 64'd0;
            e.err   = 1'b0;
            ref_mem[ref_idx(addr)] = wdata;
        end else begin
            e.rdata = ref_mem[ref_idx(addr)];
            e.err   = 1'b0;
        end
        sb.push_back(e);
        step();
        // Noise on the request port while the unit is busy must be ignored.
        req_valid = 1'($urandom);
        req_we    = 1'($urandom);
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
        n = 0;
        while (!resp_valid && n < LATENCY + 5) begin
            step();
            n++;
        end
        if (!resp_valid) begin
            check({tag, "_resp_timeout"}, {63'd0, resp_valid}, 64'd1);
            req_valid = 1'b0;
            sb.delete();
            return;
        end
        repeat (delay) step();
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        check({tag, "_idle_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_idle_resp_valid"}, {63'd0, resp_valid}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d, a;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        for (int i = 0; i < 256; i++) begin
            d = {$urandom, $urandom};
            dut.u_mem.memory[i] = d;
            ref_mem[i] = d;
        end

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {63'd0, req_ready}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_resp_rdata", resp_rdata, 64'd0);
        check("rst_resp_err", {63'd0, resp_err}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 check("post_rst_req_ready", {63'd0, req_ready}, 64'd1);

        // Store 15 to byte address 16
        issue("store16", 1'b1, 64'd16, 64'd15, 0);
        check("store16_mem2", dut.u_mem.memory[2], 64'd15);

        // Preloaded word read back, then held for three cycles, then aliased address
        dut.u_mem.memory[1] = 64'd20;
        ref_mem[1] = 64'd20;
        issue("load8", 1'b0, 64'd8, 64'd0, 0);
        issue("load8_hold", 1'b0, 64'd8, 64'd0, 3);
        issue("load2056", 1'b0, 64'd2056, 64'd0, 1);

        // Reset while a store sits in WAIT
        wait_ready();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 64'd24;
        req_wdata = 64'd99;
        step();
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_wait_busy", {63'd0, busy}, 64'd0);
        check("rst_wait_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_wait_req_ready", {63'd0, req_ready}, 64'd0);
        sb.delete();
        repeat (2) step();
        rst = 1'b0;
        step();
        check("rst_wait_mem3", dut.u_mem.memory[3], ref_mem[3]);

        // Misaligned store to byte address 12
        issue("store12", 1'b1, 64'd12, 64'hA5A5_0000_1234_5678, 0);
        check("store12_mem1", dut.u_mem.memory[1], ref_mem[1]);

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            a = {$urandom, $urandom};
            if ($urandom_range(1, 0) == 1) a[2:0] = 3'd0;
            if ($urandom_range(3, 0) == 0) a[63:11] = '0;
            issue($sformatf("rand%0d", t), 1'($urandom), a, {$urandom, $urandom},
                  int'($urandom_range(3, 0)));
        end

        for (int i = 0; i < 256; i++) begin
            check($sformatf("final_mem%0d", i), dut.u_mem.memory[i], ref_mem[i]);
        end
        repeat (3) step();
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
